instr_fetch_unit: RTL and testbench

//  Front end that produces the 32-bit instruction stream consumed by the decoder/control unit.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/instr_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv_pkg
// Description : Shared fetch-path types and constants.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int          RV_XLEN   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_BOOT  = 2'd0,
        FS_RUN   = 2'd1,
        FS_FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]        instr;
        logic [RV_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO of fetched {instr, pc} entries with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  fetch_entry_t           i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    always_comb begin
        o_count   = r_count;
        o_full    = (r_count == (AW+1)'(DEPTH));
        o_empty   = (r_count == '0);
        o_head    = r_mem[r_rd_ptr];
        w_do_push = i_push & ~o_full;
        w_do_pop  = i_pop & ~o_empty;
    end

    // Flush wins over a same-cycle push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch front end: PC, imem requests, buffer, redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN       = RV_XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4
);

    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]   c_DEPTH = (CW+1)'(FIFO_DEPTH);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [XLEN-1:0] r_hold_addr;
    logic            r_hold;
    logic            r_hold_stale;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop;

    logic [XLEN-1:0] w_target;
    logic            w_issue;
    logic            w_req_fire;
    logic            w_req_live;
    logic            w_hold_next;
    logic            w_rsp_drop;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_outstanding_next;
    logic [CW-1:0]   w_drop_next;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_fifo_head;
    logic [CW-1:0]   w_fifo_count;
    logic            w_fifo_full;
    logic            w_fifo_empty;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_comb begin
        w_target = redirect_pc & ~XLEN'(3);
        // Buffered plus in-flight never exceeds the FIFO, so responses always fit.
        w_issue  = (r_state == FS_RUN) && !r_hold && !w_fifo_full &&
                   (({1'b0, w_fifo_count} + {1'b0, r_outstanding}) < c_DEPTH);

        imem_req_valid = r_hold | w_issue;
        imem_req_addr  = r_hold ? r_hold_addr : r_fetch_pc;
        w_req_fire     = imem_req_valid & imem_req_ready;
        w_req_live     = w_req_fire & ~(r_hold & r_hold_stale);
        w_hold_next    = imem_req_valid & ~imem_req_ready;

        w_rsp_drop = imem_rsp_valid & (redirect_valid | (r_drop != '0));
        w_push     = imem_rsp_valid & ~w_rsp_drop;
        w_pop      = if_valid & if_ready;

        w_push_entry.instr = imem_rsp_data;
        w_push_entry.pc    = r_rsp_pc;

        w_outstanding_next = r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);

        // On redirect every in-flight or still-held request belongs to the old stream.
        if (redirect_valid) begin
            w_drop_next = w_outstanding_next + CW'(w_hold_next);
        end else if (imem_rsp_valid && (r_drop != '0)) begin
            w_drop_next = r_drop - CW'(1);
        end else begin
            w_drop_next = r_drop;
        end

        w_state_next = r_state;
        case (r_state)
            FS_BOOT:  w_state_next = FS_RUN;
            FS_RUN:   if (redirect_valid && (w_drop_next != '0)) w_state_next = FS_FLUSH;
            FS_FLUSH: if (w_drop_next == '0) w_state_next = FS_RUN;
            default:  w_state_next = FS_BOOT;
        endcase

        if_valid    = ~w_fifo_empty;
        if_instr    = if_valid ? w_fifo_head.instr : NOP_INSTR;
        if_pc       = if_valid ? w_fifo_head.pc : r_rsp_pc;
        if_pc_plus4 = if_pc + XLEN'(4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= FS_BOOT;
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_hold_addr   <= RESET_PC;
            r_hold        <= 1'b0;
            r_hold_stale  <= 1'b0;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_outstanding_next;
            r_drop        <= w_drop_next;
            r_hold        <= w_hold_next;
            r_hold_stale  <= w_hold_next & (redirect_valid | (r_hold & r_hold_stale));
            if (w_hold_next) r_hold_addr <= imem_req_addr;
            if (redirect_valid) begin
                r_fetch_pc <= w_target;
                r_rsp_pc   <= w_target;
            end else begin
                if (w_req_live) r_fetch_pc <= r_fetch_pc + XLEN'(4);
                if (w_push)     r_rsp_pc   <= r_rsp_pc + XLEN'(4);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int FIFO_DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    int          n_checks   = 0;
    int          n_fail     = 0;
    int          n_consumed = 0;
    int          acc_cnt    = 0;
    int          mem_lat    = 1;
    int          c0;
    logic [31:0] exp_pc     = 32'h0;
    logic        wrap_seen  = 1'b0;
    logic [31:0] wrap_pc4   = 32'hDEAD_BEEF;

    instr_fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // In-order memory model with programmable latency.
    logic        pv [4];
    logic [31:0] pa [4];
    initial begin
        logic        acc;
        logic [31:0] acc_a;
        for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pa[i] = '0; end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            acc   = imem_req_valid && imem_req_ready && !rst;
            acc_a = imem_req_addr;
            if (acc) acc_cnt++;
            @(posedge clk);
            #1;
            if (rst) begin
                for (int i = 0; i < 4; i++) pv[i] = 1'b0;
            end else begin
                for (int i = 0; i < 3; i++) begin pv[i] = pv[i+1]; pa[i] = pa[i+1]; end
                pv[3] = 1'b0;
                if (acc) begin pv[mem_lat-1] = 1'b1; pa[mem_lat-1] = acc_a; end
            end
            imem_rsp_valid = pv[0];
            imem_rsp_data  = pv[0] ? imem_word(pa[0]) : 32'h0;
        end
    end

    // Decode-side monitor: every consumed word must be the next expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && if_valid && if_ready) begin
                check_eq("stream_pc", if_pc, exp_pc);
                check_eq("stream_instr", if_instr, imem_word(exp_pc));
                check_eq("stream_pc4", if_pc_plus4, exp_pc + 32'd4);
                if (if_pc == 32'hFFFF_FFFC) begin
                    wrap_seen = 1'b1;
                    wrap_pc4  = if_pc_plus4;
                end
                exp_pc = exp_pc + 32'd4;
                n_consumed++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0;
        redirect_pc = 32'h0; if_ready = 1'b1;

        @(negedge clk);
        check_eq("rst_req_valid", imem_req_valid, 1'b0);
        check_eq("rst_req_addr", imem_req_addr, 32'h0);
        check_eq("rst_if_valid", if_valid, 1'b0);
        check_eq("rst_if_instr", if_instr, 32'h0000_0013);
        check_eq("rst_if_pc", if_pc, 32'h0);

        // Boot sequence with 1-cycle memory.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); check_eq("boot_c1_req", imem_req_valid, 1'b0);
        @(negedge clk); check_eq("boot_c2_req", imem_req_valid, 1'b1);
                        check_eq("boot_c2_addr", imem_req_addr, 32'h0);
        @(negedge clk); check_eq("boot_c3_ifv", if_valid, 1'b0);
                        check_eq("boot_c3_addr", imem_req_addr, 32'h4);
        @(negedge clk); check_eq("boot_c4_ifv", if_valid, 1'b1);
                        check_eq("boot_c4_pc", if_pc, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); check_eq("thru_ifv", if_valid, 1'b1);
        end

        // Decode backpressure fills the buffer and stops issue.
        @(posedge clk); #1 if_ready = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check_eq("bp_no_req", imem_req_valid, 1'b0);
        check_eq("bp_buffered", acc_cnt - n_consumed, FIFO_DEPTH);
        mem_lat = 2;
        @(posedge clk); #1 if_ready = 1'b1; c0 = n_consumed;
        repeat (12) @(negedge clk);
        #1 check_eq("bp_release_cnt", n_consumed - c0, 12);

        // Redirect with two responses in flight.
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        @(posedge clk); #1 redirect_valid = 1'b0; exp_pc = 32'h100;
        @(negedge clk); check_eq("rd_flush_req1", imem_req_valid, 1'b0);
                        check_eq("rd_flush_ifv", if_valid, 1'b0);
        @(negedge clk); check_eq("rd_flush_req2", imem_req_valid, 1'b0);
        @(posedge clk); #1 imem_req_ready = 1'b0;
        @(negedge clk); check_eq("rd_new_req", imem_req_valid, 1'b1);
                        check_eq("rd_new_addr", imem_req_addr, 32'h100);

        // Held request, redirect to an unaligned target mid-hold.
        for (int i = 4; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 5) begin redirect_valid = 1'b1; redirect_pc = 32'h203; end
            if (i == 6) begin redirect_valid = 1'b0; exp_pc = 32'h200; end
            if (i == 8) imem_req_ready = 1'b1;
            @(negedge clk);
            check_eq("hold_valid", imem_req_valid, 1'b1);
            check_eq("hold_addr", imem_req_addr, 32'h100);
        end
        @(negedge clk); check_eq("hold_flush_req1", imem_req_valid, 1'b0);
        @(negedge clk); check_eq("hold_flush_req2", imem_req_valid, 1'b0);
                        check_eq("hold_flush_ifv", if_valid, 1'b0);
        @(negedge clk); check_eq("hold_new_req", imem_req_valid, 1'b1);
                        check_eq("hold_new_addr", imem_req_addr, 32'h200);
        #1 c0 = n_consumed;
        repeat (10) @(negedge clk);
        #1 check_eq("hold_after_cnt", n_consumed - c0, 8);

        // Address wrap at the top of the space.
        @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        @(negedge clk);
        @(posedge clk); #1 redirect_valid = 1'b0; exp_pc = 32'hFFFF_FFF8; c0 = n_consumed;
        repeat (10) @(negedge clk);
        #1;
        check_eq("wrap_cnt", n_consumed - c0, 5);
        check_eq("wrap_seen", wrap_seen, 1'b1);
        check_eq("wrap_pc4", wrap_pc4, 32'h0);

        // Asynchronous reset between clock edges.
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check_eq("ar_req_valid", imem_req_valid, 1'b0);
        check_eq("ar_if_valid", if_valid, 1'b0);
        check_eq("ar_if_instr", if_instr, 32'h0000_0013);
        check_eq("ar_if_pc", if_pc, 32'h0);
        mem_lat = 1; exp_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; c0 = n_consumed;
        @(negedge clk); check_eq("ar_c1_req", imem_req_valid, 1'b0);
        @(negedge clk); check_eq("ar_c2_req", imem_req_valid, 1'b1);
                        check_eq("ar_c2_addr", imem_req_addr, 32'h0);
        repeat (8) @(negedge clk);
        #1 check_eq("ar_restart_cnt", n_consumed - c0, 7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
